// File: rtl/rv_axi4_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_axi4_ar_intf / rv_axi4_r_intf
// Brief    : AXI4 read-address and read-data channel bundles with in/out views.
// Revision : 1.0 - initial release
// ============================================================================

interface rv_axi4_ar_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [1:0]            ARBURST;
    logic [3:0]            ARCACHE;
    logic [7:0]            ARLEN;
    logic                  ARLOCK;
    logic [2:0]            ARPROT;
    logic [3:0]            ARQOS;
    logic [2:0]            ARSIZE;
    logic [USER_WIDTH-1:0] ARUSER;
    logic [ID_WIDTH-1:0]   ARID;

    modport in (
        input  ARVALID, ARADDR, ARBURST, ARCACHE, ARLEN, ARLOCK,
               ARPROT, ARQOS, ARSIZE, ARUSER, ARID,
        output ARREADY
    );

    modport out (
        output ARVALID, ARADDR, ARBURST, ARCACHE, ARLEN, ARLOCK,
               ARPROT, ARQOS, ARSIZE, ARUSER, ARID,
        input  ARREADY
    );
endinterface

interface rv_axi4_r_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic [1:0]            RRESP;
    logic [ID_WIDTH-1:0]   RID;

    modport out (
        output RVALID, RDATA, RLAST, RRESP, RID,
        input  RREADY
    );

    modport in (
        input  RVALID, RDATA, RLAST, RRESP, RID,
        output RREADY
    );
endinterface

`default_nettype wire

// File: rtl/rv_axi4_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_axi4_read_arbiter
// Brief    : Round-robin sharing of one AXI4 read port between two requesters,
//            one burst outstanding, beat-counted burst end with RLAST checking.
// Revision : 1.0 - initial release
// ============================================================================

module rv_axi4_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rv_axi4_ar_intf.in    req0_ar,
    rv_axi4_r_intf.out    req0_r,
    rv_axi4_ar_intf.in    req1_ar,
    rv_axi4_r_intf.out    req1_r,
    rv_axi4_ar_intf.out   mem_ar,
    rv_axi4_r_intf.in     mem_r,
    output logic          rlast_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    logic            grant;
    logic            rr_next;
    logic [7:0]      len_q;
    logic [8:0]      beat_cnt;

    logic                  in_addr;
    logic                  in_data;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_burst;
    logic [3:0]            sel_cache;
    logic [7:0]            sel_len;
    logic                  sel_lock;
    logic [2:0]            sel_prot;
    logic [3:0]            sel_qos;
    logic [2:0]            sel_size;
    logic [USER_WIDTH-1:0] sel_user;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  sel_rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_beat;

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    always_comb begin
        if (grant) begin
            sel_valid  = req1_ar.ARVALID;
            sel_addr   = req1_ar.ARADDR;
            sel_burst  = req1_ar.ARBURST;
            sel_cache  = req1_ar.ARCACHE;
            sel_len    = req1_ar.ARLEN;
            sel_lock   = req1_ar.ARLOCK;
            sel_prot   = req1_ar.ARPROT;
            sel_qos    = req1_ar.ARQOS;
            sel_size   = req1_ar.ARSIZE;
            sel_user   = req1_ar.ARUSER;
            sel_id     = req1_ar.ARID;
            sel_rready = req1_r.RREADY;
        end else begin
            sel_valid  = req0_ar.ARVALID;
            sel_addr   = req0_ar.ARADDR;
            sel_burst  = req0_ar.ARBURST;
            sel_cache  = req0_ar.ARCACHE;
            sel_len    = req0_ar.ARLEN;
            sel_lock   = req0_ar.ARLOCK;
            sel_prot   = req0_ar.ARPROT;
            sel_qos    = req0_ar.ARQOS;
            sel_size   = req0_ar.ARSIZE;
            sel_user   = req0_ar.ARUSER;
            sel_id     = req0_ar.ARID;
            sel_rready = req0_r.RREADY;
        end
    end

    // Handshake outputs are gated by the registered state only, so slave
    // ARREADY never feeds back into ARVALID.
    assign mem_ar.ARVALID = in_addr & sel_valid;
    assign mem_ar.ARADDR  = sel_addr;
    assign mem_ar.ARBURST = sel_burst;
    assign mem_ar.ARCACHE = sel_cache;
    assign mem_ar.ARLEN   = sel_len;
    assign mem_ar.ARLOCK  = sel_lock;
    assign mem_ar.ARPROT  = sel_prot;
    assign mem_ar.ARQOS   = sel_qos;
    assign mem_ar.ARSIZE  = sel_size;
    assign mem_ar.ARUSER  = sel_user;
    assign mem_ar.ARID    = sel_id;

    assign req0_ar.ARREADY = in_addr & ~grant & mem_ar.ARREADY;
    assign req1_ar.ARREADY = in_addr &  grant & mem_ar.ARREADY;

    assign rdata = mem_r.RDATA;
    assign rid   = mem_r.RID;

    assign req0_r.RVALID = in_data & ~grant & mem_r.RVALID;
    assign req0_r.RDATA  = rdata;
    assign req0_r.RLAST  = mem_r.RLAST;
    assign req0_r.RRESP  = mem_r.RRESP;
    assign req0_r.RID    = rid;

    assign req1_r.RVALID = in_data &  grant & mem_r.RVALID;
    assign req1_r.RDATA  = rdata;
    assign req1_r.RLAST  = mem_r.RLAST;
    assign req1_r.RRESP  = mem_r.RRESP;
    assign req1_r.RID    = rid;

    assign mem_r.RREADY = in_data & sel_rready;

    assign ar_hs     = in_addr & sel_valid & mem_ar.ARREADY;
    assign r_hs      = in_data & mem_r.RVALID & sel_rready;
    assign last_beat = (beat_cnt == {1'b0, len_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 1'b0;
            rr_next   <= 1'b0;
            len_q     <= 8'd0;
            beat_cnt  <= 9'd0;
            rlast_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ar.ARVALID | req1_ar.ARVALID) begin
                        grant <= (req0_ar.ARVALID & req1_ar.ARVALID) ? rr_next
                                                                     : req1_ar.ARVALID;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q    <= sel_len;
                        beat_cnt <= 9'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        // The beat counter decides the burst end; RLAST is only audited.
                        if (mem_r.RLAST != last_beat) begin
                            rlast_err <= 1'b1;
                        end
                        if (last_beat) begin
                            state   <= IDLE;
                            rr_next <= ~grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_axi4_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_axi4_read_arbiter
// Brief    : Vector table plus hand-written sequences against a scoreboarded slave.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rv_axi4_read_arbiter;

    logic clk;
    logic rst_n;
    logic rlast_err;

    rv_axi4_ar_intf #(.ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) req0_ar_if ();
    rv_axi4_ar_intf #(.ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) req1_ar_if ();
    rv_axi4_ar_intf #(.ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) mem_ar_if ();
    rv_axi4_r_intf  #(.DATA_WIDTH(32), .ID_WIDTH(1)) req0_r_if ();
    rv_axi4_r_intf  #(.DATA_WIDTH(32), .ID_WIDTH(1)) req1_r_if ();
    rv_axi4_r_intf  #(.DATA_WIDTH(32), .ID_WIDTH(1)) mem_r_if ();

    rv_axi4_read_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_ar   (req0_ar_if),
        .req0_r    (req0_r_if),
        .req1_ar   (req1_ar_if),
        .req1_r    (req1_r_if),
        .mem_ar    (mem_ar_if),
        .mem_r     (mem_r_if),
        .rlast_err (rlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        logic [31:0] addr;
        logic [7:0]  len;
        int          mode;    // 0 proper RLAST, 1 extra RLAST on second beat, 2 no RLAST
        int          slv;     // beat index answered with SLVERR, -1 for none
        int          dly;     // cycles the slave holds ARREADY low
        bit          tog;     // requester 1 toggles RREADY
        bit          rst;     // reset before the vector
        bit          err;     // expected rlast_err afterwards
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        id;
        int          mode;
        int          slv;
    } arx_t;

    beat_t q0[$];
    beat_t q1[$];
    arx_t  qa[$];

    int n_chk = 0;
    int n_pass = 0;
    int rx_cnt[2];
    int ar_dly = 0;
    bit tog1 = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        logic [15:0] bb;
        bb = b[15:0];
        return {a[15:0] + bb, 16'hC0DE ^ bb};
    endfunction

    function automatic logic last_of(input int mode, input int b, input int len);
        if (mode == 1) return (b == 1) || (b == len);
        if (mode == 2) return 1'b0;
        return (b == len);
    endfunction

    // ---------------- slave model ----------------
    int          s_phase = 0;
    bit          s_seen = 1'b0;
    int          s_wait, s_beat, s_len, s_mode, s_slv;
    logic [31:0] s_addr, s_first_addr;
    logic        s_id;
    logic        smp_arv, smp_arhs, smp_rhs, smp_id, smp_user;
    logic [31:0] smp_addr;
    logic [7:0]  smp_len;
    logic [1:0]  smp_burst;

    task automatic present(input int b);
        mem_r_if.RVALID = 1'b1;
        mem_r_if.RDATA  = beat_data(s_addr, b);
        mem_r_if.RLAST  = last_of(s_mode, b, s_len);
        mem_r_if.RRESP  = (b == s_slv) ? 2'b10 : 2'b00;
        mem_r_if.RID    = s_id;
    endtask

    initial begin : slave
        arx_t e;
        mem_ar_if.ARREADY = 1'b0;
        mem_r_if.RVALID = 1'b0;
        mem_r_if.RDATA = '0;
        mem_r_if.RLAST = 1'b0;
        mem_r_if.RRESP = 2'b00;
        mem_r_if.RID = 1'b0;
        forever begin
            @(negedge clk);
            smp_arv   = mem_ar_if.ARVALID;
            smp_arhs  = mem_ar_if.ARVALID & mem_ar_if.ARREADY;
            smp_rhs   = mem_r_if.RVALID & mem_r_if.RREADY;
            smp_addr  = mem_ar_if.ARADDR;
            smp_len   = mem_ar_if.ARLEN;
            smp_id    = mem_ar_if.ARID;
            smp_user  = mem_ar_if.ARUSER;
            smp_burst = mem_ar_if.ARBURST;
            if (rst_n && s_phase == 0 && s_seen) begin
                check("ar_hold_valid", smp_arv, 1);
                check("ar_hold_addr", smp_addr, s_first_addr);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_phase = 0;
                s_seen = 1'b0;
                mem_ar_if.ARREADY = 1'b0;
                mem_r_if.RVALID = 1'b0;
                mem_r_if.RLAST = 1'b0;
                continue;
            end
            if (s_phase == 0) begin
                if (smp_arhs) begin
                    mem_ar_if.ARREADY = 1'b0;
                    s_seen = 1'b0;
                    if (qa.size() == 0) begin
                        check("ar_unexpected", 1, 0);
                        e = '{smp_addr, smp_len, smp_id, 0, -1};
                    end else begin
                        e = qa.pop_front();
                    end
                    check("ar_addr", smp_addr, e.addr);
                    check("ar_len", smp_len, e.len);
                    check("ar_id", smp_id, e.id);
                    check("ar_user", smp_user, e.id);
                    check("ar_burst", smp_burst, 2'b01);
                    s_addr = smp_addr;
                    s_len = int'(smp_len);
                    s_id = smp_id;
                    s_mode = e.mode;
                    s_slv = e.slv;
                    s_beat = 0;
                    s_phase = 1;
                    present(0);
                end else if (smp_arv) begin
                    if (!s_seen) begin
                        s_seen = 1'b1;
                        s_first_addr = smp_addr;
                        s_wait = 0;
                    end
                    if (s_wait >= ar_dly) mem_ar_if.ARREADY = 1'b1;
                    else s_wait++;
                end
            end else if (smp_rhs) begin
                s_beat++;
                if (s_beat > s_len) begin
                    mem_r_if.RVALID = 1'b0;
                    mem_r_if.RLAST = 1'b0;
                    s_phase = 0;
                end else begin
                    present(s_beat);
                end
            end
        end
    end

    // ---------------- requester-side monitor ----------------
    task automatic got_beat(input bit who, input logic [31:0] d, input logic [1:0] rs,
                            input logic l, input logic id);
        beat_t e;
        bit    empty;
        rx_cnt[who]++;
        empty = who ? (q1.size() == 0) : (q0.size() == 0);
        if (empty) begin
            check($sformatf("r%0d_stray_beat", who), 1, 0);
        end else begin
            if (who) e = q1.pop_front();
            else     e = q0.pop_front();
            check($sformatf("r%0d_data", who), d, e.data);
            check($sformatf("r%0d_resp", who), rs, e.resp);
            check($sformatf("r%0d_last", who), l, e.last);
            check($sformatf("r%0d_id", who), id, e.id);
        end
    endtask

    initial begin : monitor
        req0_r_if.RREADY = 1'b1;
        req1_r_if.RREADY = 1'b1;
        forever begin
            @(negedge clk);
            if (req0_r_if.RVALID && req0_r_if.RREADY)
                got_beat(1'b0, req0_r_if.RDATA, req0_r_if.RRESP, req0_r_if.RLAST, req0_r_if.RID);
            if (req1_r_if.RVALID && req1_r_if.RREADY)
                got_beat(1'b1, req1_r_if.RDATA, req1_r_if.RRESP, req1_r_if.RLAST, req1_r_if.RID);
            @(posedge clk);
            #1;
            req1_r_if.RREADY = tog1 ? ~req1_r_if.RREADY : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ar(input bit who, input logic v, input logic [31:0] a, input logic [7:0] len);
        if (who) begin
            req1_ar_if.ARVALID = v;  req1_ar_if.ARADDR = a;   req1_ar_if.ARLEN = len;
            req1_ar_if.ARBURST = 2'b01; req1_ar_if.ARSIZE = 3'd2; req1_ar_if.ARCACHE = 4'h3;
            req1_ar_if.ARLOCK = 1'b0; req1_ar_if.ARPROT = 3'd0; req1_ar_if.ARQOS = 4'd0;
            req1_ar_if.ARUSER = 1'b1; req1_ar_if.ARID = 1'b1;
        end else begin
            req0_ar_if.ARVALID = v;  req0_ar_if.ARADDR = a;   req0_ar_if.ARLEN = len;
            req0_ar_if.ARBURST = 2'b01; req0_ar_if.ARSIZE = 3'd2; req0_ar_if.ARCACHE = 4'h3;
            req0_ar_if.ARLOCK = 1'b0; req0_ar_if.ARPROT = 3'd0; req0_ar_if.ARQOS = 4'd0;
            req0_ar_if.ARUSER = 1'b0; req0_ar_if.ARID = 1'b0;
        end
    endtask

    task automatic push_exp(input bit who, input logic [31:0] a, input logic [7:0] len,
                            input int mode, input int slv);
        beat_t b;
        qa.push_back('{a, len, who, mode, slv});
        for (int k = 0; k <= int'(len); k++) begin
            b.data = beat_data(a, k);
            b.resp = (k == slv) ? 2'b10 : 2'b00;
            b.last = last_of(mode, k, int'(len));
            b.id   = who;
            if (who) q1.push_back(b);
            else     q0.push_back(b);
        end
    endtask

    task automatic drive_ar(input bit who, input logic [31:0] a, input logic [7:0] len);
        int   n;
        logic rdy;
        set_ar(who, 1'b1, a, len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = who ? req1_ar_if.ARREADY : req0_ar_if.ARREADY;
        end while (!rdy && n < 2000);
        check($sformatf("ar%0d_accepted", who), rdy, 1);
        @(posedge clk);
        #1;
        set_ar(who, 1'b0, a, len);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_ar(1'b0, 1'b0, 32'h0, 8'h0);
        set_ar(1'b1, 1'b0, 32'h0, 8'h0);
        repeat (2) @(negedge clk);
        check("rst_rlast_err", rlast_err, 0);
        check("rst_mem_arvalid", mem_ar_if.ARVALID, 0);
        check("rst_mem_rready", mem_r_if.RREADY, 0);
        check("rst_arready", {req0_ar_if.ARREADY, req1_ar_if.ARREADY}, 0);
        check("rst_rvalid", {req0_r_if.RVALID, req1_r_if.RVALID}, 0);
        q0.delete(); q1.delete(); qa.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || qa.size() != 0 || s_phase != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, n < 3000, 1);
        if (n >= 3000) do_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t vt[7];

    initial begin : main
        int n;
        rst_n = 1'b0;
        set_ar(1'b0, 1'b0, 32'h0, 8'h0);
        set_ar(1'b1, 1'b0, 32'h0, 8'h0);

        //           who   addr          len     mode slv dly tog   rst   err
        vt[0] = '{1'b0, 32'h0000_0100, 8'd3,   0,  -1, 0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 32'h0000_0200, 8'd7,   0,  -1, 5, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 32'h0000_0300, 8'd0,   0,  -1, 0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 32'h0000_0400, 8'd255, 0,   9, 0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 32'h0000_0500, 8'd3,   1,  -1, 0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 32'h0000_0600, 8'd1,   0,  -1, 0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{1'b0, 32'h0000_0700, 8'd3,   2,  -1, 0, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 7; i++) begin
            if (vt[i].rst) do_reset();
            ar_dly = vt[i].dly;
            tog1 = vt[i].tog;
            rx_cnt[0] = 0;
            rx_cnt[1] = 0;
            push_exp(vt[i].who, vt[i].addr, vt[i].len, vt[i].mode, vt[i].slv);
            fork
                drive_ar(vt[i].who, vt[i].addr, vt[i].len);
                begin
                    if (vt[i].dly == 0) begin
                        @(negedge clk);
                        check($sformatf("v%0d_arb_bubble", i), mem_ar_if.ARVALID, 0);
                        @(negedge clk);
                        check($sformatf("v%0d_ar_valid_next", i), mem_ar_if.ARVALID, 1);
                        check($sformatf("v%0d_ar_addr_next", i), mem_ar_if.ARADDR, vt[i].addr);
                    end
                end
            join
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_beats_granted", i), rx_cnt[vt[i].who], int'(vt[i].len) + 1);
            check($sformatf("v%0d_beats_other", i), rx_cnt[!vt[i].who], 0);
            check($sformatf("v%0d_rlast_err", i), rlast_err, vt[i].err);
            tog1 = 1'b0;
            ar_dly = 0;
        end

        // Contention straight after reset: both requesters keep a request pending,
        // so grants must alternate req0, req1, req0, req1.
        do_reset();
        rx_cnt[0] = 0;
        rx_cnt[1] = 0;
        push_exp(1'b0, 32'h0000_1000, 8'd1, 0, -1);
        push_exp(1'b1, 32'h0000_2000, 8'd1, 0, -1);
        push_exp(1'b0, 32'h0000_1100, 8'd1, 0, -1);
        push_exp(1'b1, 32'h0000_2100, 8'd1, 0, -1);
        fork
            begin
                drive_ar(1'b0, 32'h0000_1000, 8'd1);
                drive_ar(1'b0, 32'h0000_1100, 8'd1);
            end
            begin
                drive_ar(1'b1, 32'h0000_2000, 8'd1);
                drive_ar(1'b1, 32'h0000_2100, 8'd1);
            end
        join
        wait_done("rr");
        check("rr_beats_req0", rx_cnt[0], 4);
        check("rr_beats_req1", rx_cnt[1], 4);
        check("rr_rlast_err", rlast_err, 0);

        // Reset while the second beat of a burst is on the bus.
        rx_cnt[0] = 0;
        push_exp(1'b0, 32'h0000_0800, 8'd3, 0, -1);
        drive_ar(1'b0, 32'h0000_0800, 8'd3);
        n = 0;
        while (rx_cnt[0] < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_first_beat_seen", rx_cnt[0], 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req0_rvalid", req0_r_if.RVALID, 0);
        check("mid_rst_req1_rvalid", req1_r_if.RVALID, 0);
        check("mid_rst_mem_rready", mem_r_if.RREADY, 0);
        check("mid_rst_mem_arvalid", mem_ar_if.ARVALID, 0);
        check("mid_rst_arready", {req0_ar_if.ARREADY, req1_ar_if.ARREADY}, 0);
        q0.delete(); q1.delete(); qa.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_cnt[0] = 0;
        rx_cnt[1] = 0;
        push_exp(1'b1, 32'h0000_0900, 8'd2, 0, -1);
        drive_ar(1'b1, 32'h0000_0900, 8'd2);
        wait_done("post_rst");
        check("post_rst_beats_req1", rx_cnt[1], 3);
        check("post_rst_beats_req0", rx_cnt[0], 0);
        check("post_rst_rlast_err", rlast_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
